player_motion: RTL and testbench
================================

# player_motion

Per-fighter motion controller driven once per video frame by the scan-enable tick `SCEN`. It generalises the fixed-table player mover with a parametrised gravity jump arc, walk and air speeds, and wall clamping applied to the next position rather than the current one. It adds opponent body-blocking and a timed knockback state. It sits between the input/attack FSM and the sprite renderer and hit-box logic, and one instance is used per player.

## Interface
- `POS_WIDTH`, 10: unsigned screen-coordinate width.
- `GROUND_Y`, 400: resting y; smaller y is higher on screen.
- `START_X`, 100: x after reset.
- `MIN_X` / `MAX_X`, 40 / 600: inclusive x limits.
- `WALK_SPEED`, 2: px per frame while walking.
- `AIR_SPEED`, 3: horizontal px per frame, locked at takeoff.
- `JUMP_VEL`, 12: initial upward speed, px per frame.
- `GRAVITY`, 1: added to vy each air frame.
- `MIN_GAP`, 32: minimum grounded x-separation from the opponent.
- `KB_FRAMES` / `KB_SPEED`, 8 / 4: knockback duration and px per frame.
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `SCEN`, in, 1: one-cycle frame tick.
- `move_enable`, in, 1: when low, all state is frozen.
- `move_left` / `move_right` / `jump`, in, 1 each: levels sampled on `SCEN`.
- `hit`, in, 1: pulse that starts a knockback; latched until the next `SCEN`.
- `opponent_x`, in, POS_WIDTH: opponent x position.
- `pos_x` / `pos_y`, out, POS_WIDTH: current position.
- `facing_right`, out, 1: facing direction.
- `state`, out, 2: encoded as IDLE=0, WALK=1, AIR=2, KNOCK=3.
- `jump_active`, out, 1: high while `state` is AIR, or KNOCK while airborne.
- `move_active`, out, 1: position changed on the last frame.
- `landed`, out, 1: one-`clk` pulse on the landing frame.

## Operation
- **Reset values:** `pos_x`=START_X, `pos_y`=GROUND_Y, `facing_right`=1, state IDLE, vx=vy=0, knockback counter=0, all flags 0.
- **Update rule:** state changes only on cycles where `SCEN && move_enable`.
- **IDLE / WALK:**
  - Exactly one of `move_left`/`move_right` → WALK at ±WALK_SPEED.
  - Neither or both → IDLE.
  - `jump` has priority over walking: go to AIR with vy=−JUMP_VEL.
  - On takeoff, vx = ±AIR_SPEED if exactly one direction is held, else 0. The first arc step is applied on the same frame.
- **AIR:**
  - Each frame: pos_y += vy, vy += GRAVITY, pos_x += vx.
  - Directional inputs are ignored.
  - When pos_y+vy ≥ GROUND_Y: set pos_y=GROUND_Y, vy=0, pulse `landed`, go to IDLE.
- **KNOCK:**
  - A latched `hit` wins over every other input in any state. Load the counter with KB_FRAMES and set the direction away from `opponent_x` (left if pos_x < opponent_x; right if greater or equal).
  - Each frame: move KB_SPEED in that direction and decrement the counter.
  - If airborne, the vertical arc continues. Landing during knockback pulses `landed` but stays in KNOCK.
  - At counter 0: go to AIR if pos_y ≠ GROUND_Y, else IDLE.
  - A new `hit` during KNOCK reloads the counter.
- **Clamping:** next_x is computed in signed POS_WIDTH+2 arithmetic and saturated to [MIN_X, MAX_X] before the register write, so there is no wrap-around. A clamp in AIR zeroes vx for the rest of the jump.
- **Body-block:** applies to grounded WALK only. A step toward the opponent that would make |next_x − opponent_x| < MIN_GAP is cancelled: position is held and `move_active`=0. Stepping away is always allowed. AIR and KNOCK ignore the block.
- **Facing:** `facing_right` = (pos_x < opponent_x). It is updated only when grounded and in IDLE/WALK; equal positions hold the previous value.
- **`move_active`:** 1 iff `pos_x` or `pos_y` changed on that frame.

## Timing
- Inputs are sampled on the `clk` edge where `SCEN`=1. Outputs are registered and valid on the next cycle.
- There are no multicycle paths.
- `landed` is high for exactly one `clk` cycle.
- With default parameters, a jump lasts 25 frames: apex at pos_y=322 after frame 12, landing on frame 25.
- `move_enable`=0 freezes the counters and vy. A `hit` arriving while frozen stays latched.
- `reset_n` asserted mid-jump or mid-knockback returns all state to its reset values immediately.

## Structure
- Package `player_pkg` holds:
  - the state enum;
  - the velocity width localparam VEL_W = POS_WIDTH+2 (signed);
  - a shared clamp function.
- Sub-module `motion_arc` holds the vy register, gravity integration and the landing compare. Interface: start, step, pos_y in/out, landed.

## Test plan
- Default parameters, `jump` held one frame with no direction → pos_y reaches 322 at frame 12, 400 at frame 25, `landed` pulses once, pos_x unchanged.
- pos_x=598, `jump`+`move_right` → pos_x clamps at 600 on the first step, vx becomes 0, and pos_x stays 600 until landing.
- pos_x=100, opponent_x=134, hold `move_right` → pos_x=102, then held at 102 with `move_active`=0; `move_left` then gives 100.
- pos_x=300, opponent_x=320, `hit` pulse → state KNOCK, pos_x falls by 4 per frame to 268 after 8 frames, then IDLE.
- `hit` at jump frame 5 → KNOCK with the arc continuing; `landed` pulses on frame 25 and state returns to IDLE after the counter expires.
- `reset_n` low at jump frame 10 → immediately pos=(100, 400), IDLE, facing_right=1, all flags 0.

Source files
------------

// File: rtl/player_pkg.sv
// rtl/player_pkg.sv - shared state encoding, widths and saturating helpers for player_motion
package player_pkg;

    localparam int POS_W = 10;
    localparam int VEL_W = POS_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WALK  = 2'd1,
        ST_AIR   = 2'd2,
        ST_KNOCK = 2'd3
    } state_t;

    typedef logic signed [VEL_W-1:0] svel_t;

    function automatic svel_t clamp_s(input svel_t v, input svel_t lo, input svel_t hi);
        svel_t r;
        if (v < lo)
            r = lo;
        else if (v > hi)
            r = hi;
        else
            r = v;
        return r;
    endfunction

    function automatic svel_t abs_s(input svel_t v);
        return (v < 0) ? -v : v;
    endfunction

endpackage

// File: rtl/motion_arc.sv
// rtl/motion_arc.sv - vertical velocity register, gravity integration and landing detect
module motion_arc
    import player_pkg::*;
#(
    parameter int POS_WIDTH = POS_W,
    parameter int GROUND_Y  = 400,
    parameter int JUMP_VEL  = 12,
    parameter int GRAVITY   = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 step,
    input  logic [POS_WIDTH-1:0] pos_y,
    output logic [POS_WIDTH-1:0] pos_y_next,
    output logic                 landed,
    output logic                 air
);

    svel_t vy;
    svel_t vy_eff;
    svel_t y_sum;
    logic  do_step;

    // Takeoff applies the first arc step on the same frame, using the launch velocity.
    always_comb begin
        vy_eff     = start ? svel_t'(-JUMP_VEL) : vy;
        do_step    = start || (step && air);
        y_sum      = svel_t'({2'b00, pos_y}) + vy_eff;
        landed     = do_step && (y_sum >= svel_t'(GROUND_Y));
        pos_y_next = pos_y;
        if (landed)
            pos_y_next = POS_WIDTH'(GROUND_Y);
        else if (do_step)
            pos_y_next = POS_WIDTH'(clamp_s(y_sum, '0, svel_t'(GROUND_Y)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vy  <= '0;
            air <= 1'b0;
        end else if (do_step) begin
            if (landed) begin
                vy  <= '0;
                air <= 1'b0;
            end else begin
                vy  <= vy_eff + svel_t'(GRAVITY);
                air <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/player_motion.sv
// rtl/player_motion.sv - per-fighter frame-rate motion controller (walk, jump arc, knockback, blocking)
module player_motion
    import player_pkg::*;
#(
    parameter int POS_WIDTH  = POS_W,
    parameter int GROUND_Y   = 400,
    parameter int START_X    = 100,
    parameter int MIN_X      = 40,
    parameter int MAX_X      = 600,
    parameter int WALK_SPEED = 2,
    parameter int AIR_SPEED  = 3,
    parameter int JUMP_VEL   = 12,
    parameter int GRAVITY    = 1,
    parameter int MIN_GAP    = 32,
    parameter int KB_FRAMES  = 8,
    parameter int KB_SPEED   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 SCEN,
    input  logic                 move_enable,
    input  logic                 move_left,
    input  logic                 move_right,
    input  logic                 jump,
    input  logic                 hit,
    input  logic [POS_WIDTH-1:0] opponent_x,
    output logic [POS_WIDTH-1:0] pos_x,
    output logic [POS_WIDTH-1:0] pos_y,
    output logic                 facing_right,
    output logic [1:0]           state,
    output logic                 jump_active,
    output logic                 move_active,
    output logic                 landed
);

    localparam int CNT_W = $clog2(KB_FRAMES + 1);

    state_t               st, st_n;
    svel_t                vx, vx_n;
    logic [CNT_W-1:0]     kb_cnt, kb_cnt_n;
    logic                 kb_left, kb_left_n;
    logic                 hit_l, facing_n;
    logic                 update, hit_now, one_dir, grounded_ctl, blocked;
    logic                 arc_start, arc_step, arc_land, air;
    svel_t                dx, x_raw, x_cl, x_cur, opp_s, dist_old, dist_new;
    logic [POS_WIDTH-1:0] x_n, y_n;

    assign update       = SCEN && move_enable;
    assign hit_now      = hit_l || hit;
    assign one_dir      = move_left ^ move_right;
    assign grounded_ctl = (st == ST_IDLE) || (st == ST_WALK);
    assign arc_start    = update && !hit_now && grounded_ctl && jump;
    assign arc_step     = update && (hit_now || st == ST_AIR || st == ST_KNOCK);

    motion_arc #(
        .POS_WIDTH (POS_WIDTH),
        .GROUND_Y  (GROUND_Y),
        .JUMP_VEL  (JUMP_VEL),
        .GRAVITY   (GRAVITY)
    ) u_arc (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (arc_start),
        .step       (arc_step),
        .pos_y      (pos_y),
        .pos_y_next (y_n),
        .landed     (arc_land),
        .air        (air)
    );

    always_comb begin
        st_n      = st;
        vx_n      = vx;
        kb_cnt_n  = kb_cnt;
        kb_left_n = kb_left;
        dx        = '0;

        if (hit_now) begin
            st_n      = ST_KNOCK;
            kb_cnt_n  = CNT_W'(KB_FRAMES);
            kb_left_n = pos_x < opponent_x;
            vx_n      = '0;
        end else begin
            case (st)
                ST_IDLE, ST_WALK: begin
                    if (jump) begin
                        st_n = ST_AIR;
                        if (!one_dir)
                            vx_n = '0;
                        else
                            vx_n = move_right ? svel_t'(AIR_SPEED) : -svel_t'(AIR_SPEED);
                        dx = vx_n;
                    end else if (one_dir) begin
                        st_n = ST_WALK;
                        dx   = move_right ? svel_t'(WALK_SPEED) : -svel_t'(WALK_SPEED);
                    end else begin
                        st_n = ST_IDLE;
                    end
                end
                ST_AIR: begin
                    dx = vx;
                    if (arc_land) begin
                        st_n = ST_IDLE;
                        vx_n = '0;
                    end
                end
                ST_KNOCK: begin
                    dx       = kb_left ? -svel_t'(KB_SPEED) : svel_t'(KB_SPEED);
                    kb_cnt_n = kb_cnt - CNT_W'(1);
                    if (kb_cnt == CNT_W'(1))
                        st_n = (air && !arc_land) ? ST_AIR : ST_IDLE;
                end
                default: st_n = ST_IDLE;
            endcase
        end

        // Saturate in the wider signed domain so steps past either wall never wrap.
        x_cur    = svel_t'({2'b00, pos_x});
        opp_s    = svel_t'({2'b00, opponent_x});
        x_raw    = x_cur + dx;
        x_cl     = clamp_s(x_raw, svel_t'(MIN_X), svel_t'(MAX_X));
        dist_old = abs_s(x_cur - opp_s);
        dist_new = abs_s(x_cl - opp_s);
        blocked  = (st_n == ST_WALK) && !hit_now && !air &&
                   (dist_new < svel_t'(MIN_GAP)) && (dist_new < dist_old);
        x_n      = blocked ? pos_x : POS_WIDTH'(x_cl);

        if ((st_n == ST_AIR) && (x_raw != x_cl))
            vx_n = '0;

        facing_n = facing_right;
        if (!hit_now && grounded_ctl && !jump && (x_n != opponent_x))
            facing_n = x_n < opponent_x;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st           <= ST_IDLE;
            vx           <= '0;
            kb_cnt       <= '0;
            kb_left      <= 1'b0;
            hit_l        <= 1'b0;
            pos_x        <= POS_WIDTH'(START_X);
            pos_y        <= POS_WIDTH'(GROUND_Y);
            facing_right <= 1'b1;
            move_active  <= 1'b0;
            landed       <= 1'b0;
        end else begin
            landed <= 1'b0;
            if (update)
                hit_l <= 1'b0;
            else if (hit)
                hit_l <= 1'b1;
            if (update) begin
                st           <= st_n;
                vx           <= vx_n;
                kb_cnt       <= kb_cnt_n;
                kb_left      <= kb_left_n;
                pos_x        <= x_n;
                pos_y        <= y_n;
                facing_right <= facing_n;
                move_active  <= (x_n != pos_x) || (y_n != pos_y);
                landed       <= arc_land;
            end
        end
    end

    assign state       = st;
    assign jump_active = (st == ST_AIR) || ((st == ST_KNOCK) && air);

endmodule

// File: tb/tb_player_motion.sv
// tb/tb_player_motion.sv - self-checking bench for player_motion
module tb_player_motion;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       SCEN = 1'b0;
    logic       move_enable = 1'b1;
    logic       move_left = 1'b0;
    logic       move_right = 1'b0;
    logic       jump = 1'b0;
    logic       hit = 1'b0;
    logic [9:0] opponent_x = 10'd300;
    logic [9:0] pos_x, pos_y;
    logic       facing_right, jump_active, move_active, landed;
    logic [1:0] state;

    player_motion dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .SCEN         (SCEN),
        .move_enable  (move_enable),
        .move_left    (move_left),
        .move_right   (move_right),
        .jump         (jump),
        .hit          (hit),
        .opponent_x   (opponent_x),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .facing_right (facing_right),
        .state        (state),
        .jump_active  (jump_active),
        .move_active  (move_active),
        .landed       (landed)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_model = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: frame-level rules in plain integers.
    int mx, my, mvy, mvx, mst, mcnt, mair, mkl, mhl, mface, mland, mact;

    task automatic model_reset();
        mx = 100; my = 400; mvy = 0; mvx = 0; mst = 0; mcnt = 0;
        mair = 0; mkl = 0; mhl = 0; mface = 1; mland = 0; mact = 0;
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic int absi(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_arc();
        if (mair != 0) begin
            if (my + mvy >= 400) begin
                my = 400; mvy = 0; mair = 0; mland = 1;
            end else begin
                my = my + mvy; mvy = mvy + 1;
            end
        end
    endtask

    task automatic model_movex(input int d, input bit zero_on_wall);
        int t;
        t = mx + d;
        if (t < 40 || t > 600) begin
            t = clampi(t, 40, 600);
            if (zero_on_wall) mvx = 0;
        end
        mx = t;
    endtask

    task automatic model_frame(input bit l, input bit r, input bit j, input bit h, input bit en, input int opp);
        int ox, oy, dir, nx;
        if (h) mhl = 1;
        mland = 0;
        if (!en) return;
        ox = mx; oy = my;
        dir = r ? 1 : -1;
        if (mhl != 0) begin
            mhl = 0; mst = 3; mcnt = 8; mkl = (mx < opp); mvx = 0;
            model_arc();
        end else if (mst == 0 || mst == 1) begin
            if (j) begin
                mst = 2; mvy = -12; mair = 1;
                mvx = (l != r) ? dir * 3 : 0;
                model_movex(mvx, 1);
                model_arc();
            end else begin
                if (l != r) begin
                    mst = 1;
                    nx = clampi(mx + dir * 2, 40, 600);
                    if (!(absi(nx - opp) < 32 && absi(nx - opp) < absi(mx - opp)))
                        mx = nx;
                end else begin
                    mst = 0;
                end
                if (mx != opp) mface = (mx < opp);
            end
        end else if (mst == 2) begin
            model_movex(mvx, 1);
            model_arc();
            if (mland != 0) begin mst = 0; mvx = 0; end
        end else begin
            model_movex((mkl != 0) ? -4 : 4, 0);
            model_arc();
            mcnt--;
            if (mcnt == 0) mst = (mair != 0) ? 2 : 0;
        end
        mact = (mx != ox || my != oy);
    endtask

    task automatic compare_model();
        chk("model pos_x", pos_x, mx);
        chk("model pos_y", pos_y, my);
        chk("model facing", facing_right, mface);
        chk("model state", state, mst);
        chk("model jump_active", jump_active, (mst == 2 || (mst == 3 && mair != 0)) ? 1 : 0);
        chk("model move_active", move_active, mact);
        chk("model landed", landed, mland);
    endtask

    task automatic frame(input bit l, input bit r, input bit j, input bit h, input bit en, input int opp);
        move_left = l; move_right = r; jump = j; move_enable = en; opponent_x = 10'(opp);
        if (h) begin
            @(negedge clk); hit = 1'b1;
            @(negedge clk); hit = 1'b0;
        end
        @(negedge clk); SCEN = 1'b1;
        @(negedge clk); SCEN = 1'b0;
        model_frame(l, r, j, h, en, opp);
        if (chk_model) compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit l, r, j, h;
        int opp, ex, ey, est, eact;
    } vec_t;

    vec_t tbl[12];

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    endtask

    initial begin
        #2ms;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        summary();
        $finish;
    end

    initial begin
        int lands, budget, all600, opp;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset pos_x", pos_x, 100);
        chk("reset pos_y", pos_y, 400);
        chk("reset facing", facing_right, 1);
        chk("reset state", state, 0);
        chk("reset jump_active", jump_active, 0);
        chk("reset move_active", move_active, 0);
        chk("reset landed", landed, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Body-block then knockback away from a close opponent.
        tbl[0] = '{0, 1, 0, 0, 134, 102, 400, 1, 1};
        tbl[1] = '{0, 1, 0, 0, 134, 102, 400, 1, 0};
        tbl[2] = '{1, 0, 0, 0, 134, 100, 400, 1, 1};
        tbl[3] = '{0, 0, 0, 1, 120, 100, 400, 3, 0};
        for (int k = 0; k < 8; k++)
            tbl[4+k] = '{0, 0, 0, 0, 120, 96 - 4 * k, 400, (k == 7) ? 0 : 3, 1};
        for (int i = 0; i < 12; i++) begin
            frame(tbl[i].l, tbl[i].r, tbl[i].j, tbl[i].h, 1, tbl[i].opp);
            chk($sformatf("tbl[%0d] pos_x", i), pos_x, tbl[i].ex);
            chk($sformatf("tbl[%0d] pos_y", i), pos_y, tbl[i].ey);
            chk($sformatf("tbl[%0d] state", i), state, tbl[i].est);
            chk($sformatf("tbl[%0d] move_active", i), move_active, tbl[i].eact);
        end

        // Plain vertical jump.
        do_reset();
        lands = 0;
        for (int f = 1; f <= 25; f++) begin
            frame(0, 0, f == 1, 0, 1, 300);
            lands += landed;
            if (f == 12) begin
                chk("jump apex pos_y", pos_y, 322);
                chk("jump apex jump_active", jump_active, 1);
            end
        end
        chk("jump land pos_y", pos_y, 400);
        chk("jump land landed", landed, 1);
        chk("jump land state", state, 0);
        chk("jump landed count", lands, 1);
        chk("jump pos_x", pos_x, 100);
        @(negedge clk);
        chk("landed pulse width", landed, 0);

        // Right-wall clamp on takeoff.
        do_reset();
        budget = 0;
        while (pos_x < 598 && budget < 400) begin
            frame(0, 1, 0, 0, 1, 0);
            budget++;
        end
        chk("walk to 598", pos_x, 598);
        all600 = 1;
        for (int f = 1; f <= 25; f++) begin
            frame(0, 1, f == 1, 0, 1, 0);
            if (pos_x != 600) all600 = 0;
        end
        chk("clamp held at 600", all600, 1);
        chk("clamp land state", state, 0);
        chk("clamp land pos_y", pos_y, 400);

        // Knockback from 300 with opponent at 320.
        budget = 0;
        while (pos_x > 300 && budget < 400) begin
            frame(1, 0, 0, 0, 1, 639);
            budget++;
        end
        chk("walk to 300", pos_x, 300);
        frame(0, 0, 0, 1, 1, 320);
        chk("knock entry state", state, 3);
        for (int f = 1; f <= 8; f++) begin
            frame(0, 0, 0, 0, 1, 320);
            if (f == 7) chk("knock f7 state", state, 3);
        end
        chk("knock end pos_x", pos_x, 268);
        chk("knock end state", state, 0);

        // Knockback during a jump: early hit re-enters AIR, late hit lands inside KNOCK.
        for (int hc = 0; hc < 2; hc++) begin
            int hf;
            hf = (hc == 0) ? 5 : 20;
            do_reset();
            for (int f = 1; f <= 30; f++) begin
                frame(0, 0, f == 1, f == hf, 1, 300);
                if (f == hf + 4) chk($sformatf("hit%0d airborne knock jump_active", hf), jump_active, 1);
                if (hc == 0 && f == 13) chk("hit5 knock expiry state", state, 2);
                if (f == 25) begin
                    chk($sformatf("hit%0d landed f25", hf), landed, 1);
                    chk($sformatf("hit%0d state f25", hf), state, (hc == 0) ? 0 : 3);
                end
            end
            chk($sformatf("hit%0d final state", hf), state, 0);
            chk($sformatf("hit%0d final pos_x", hf), pos_x, 68);
        end

        // Hit arriving while frozen is held until the next enabled frame.
        do_reset();
        frame(0, 1, 0, 1, 0, 300);
        chk("frozen pos_x", pos_x, 100);
        chk("frozen state", state, 0);
        frame(0, 1, 0, 0, 1, 300);
        chk("latched hit state", state, 3);
        chk("latched hit pos_x", pos_x, 100);

        // Asynchronous reset mid-jump.
        do_reset();
        frame(0, 0, 0, 0, 1, 50);
        chk("face left", facing_right, 0);
        for (int f = 1; f <= 10; f++) frame(0, 0, f == 1, 0, 1, 50);
        chk("jump f10 pos_y", pos_y, 325);
        chk("jump f10 move_active", move_active, 1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset pos_x", pos_x, 100);
        chk("async reset pos_y", pos_y, 400);
        chk("async reset state", state, 0);
        chk("async reset facing", facing_right, 1);
        chk("async reset jump_active", jump_active, 0);
        chk("async reset move_active", move_active, 0);
        chk("async reset landed", landed, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);

        // Randomized frames against the reference model.
        chk_model = 1;
        for (int i = 0; i < 600; i++) begin
            opp = clampi(mx + $urandom_range(0, 120) - 60, 0, 1023);
            frame($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 11) == 0), ($urandom_range(0, 7) != 0), opp);
        end
        chk_model = 0;

        summary();
        $finish;
    end

endmodule
